// File: rtl/sram_port_arb_if.sv
// sram_port_arb_if: bundles the instruction port, data port and SRAM-side signals of
// sram_port_arb. The slave modport is the arbiter's view; master is the environment's view.
interface sram_port_arb_if #(
    parameter int unsigned AWIDTH = 12
);
    // Instruction read port
    logic              I_REQ;
    logic [AWIDTH-1:0] I_ADDR;
    logic              I_GNT;
    logic              I_RVALID;
    logic [31:0]       I_RDATA;
    logic              I_RREADY;

    // Data read/write port
    logic              D_REQ;
    logic              D_WE;
    logic [AWIDTH-1:0] D_ADDR;
    logic [3:0]        D_BE;
    logic [31:0]       D_WDATA;
    logic              D_GNT;
    logic              D_RVALID;
    logic [31:0]       D_RDATA;
    logic              D_RREADY;

    // Single-port SRAM
    logic              SRAM_CSN;
    logic              SRAM_WEN;
    logic [AWIDTH-1:0] SRAM_ADDR;
    logic [3:0]        SRAM_BE;
    logic [31:0]       SRAM_DI;
    logic [31:0]       SRAM_DOUT;

    modport slave (
        input  I_REQ, I_ADDR, I_RREADY,
        input  D_REQ, D_WE, D_ADDR, D_BE, D_WDATA, D_RREADY,
        input  SRAM_DOUT,
        output I_GNT, I_RVALID, I_RDATA,
        output D_GNT, D_RVALID, D_RDATA,
        output SRAM_CSN, SRAM_WEN, SRAM_ADDR, SRAM_BE, SRAM_DI
    );

    modport master (
        output I_REQ, I_ADDR, I_RREADY,
        output D_REQ, D_WE, D_ADDR, D_BE, D_WDATA, D_RREADY,
        output SRAM_DOUT,
        input  I_GNT, I_RVALID, I_RDATA,
        input  D_GNT, D_RVALID, D_RDATA,
        input  SRAM_CSN, SRAM_WEN, SRAM_ADDR, SRAM_BE, SRAM_DI
    );
endinterface

// File: rtl/sram_port_arb.sv
// sram_port_arb: shares one single-port SRAM between an instruction read port and a data
// read/write port. One access in flight at a time: grant (IDLE) -> ACCESS -> RESP.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; without it the data
// port always wins and no priority pointer exists.
module sram_port_arb #(
    parameter int unsigned AWIDTH = 12
) (
    input logic            CLK,
    input logic            RST,
    sram_port_arb_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;          // 1 = data port owns the access
    logic              sram_csn_q, sram_csn_d;
    logic              sram_wen_q, sram_wen_d;
    logic [AWIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [3:0]        sram_be_q, sram_be_d;
    logic [31:0]       sram_di_q, sram_di_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              i_gnt, d_gnt;
    logic [31:0]       resp;
    logic              own_rready;

`ifdef SRAM_ARB_RR_EN
    logic              prio_d_q, prio_d_d;        // 1 = data port wins the next tie
`endif

    // Arbitration: grants only in IDLE and never while reset is asserted
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
`ifdef SRAM_ARB_RR_EN
        prio_d_d = prio_d_q;
`endif
        if (state_q == StIdle && !RST) begin
`ifdef SRAM_ARB_RR_EN
            if (bus.D_REQ && bus.I_REQ) begin
                d_gnt = prio_d_q;
                i_gnt = !prio_d_q;
            end else begin
                d_gnt = bus.D_REQ;
                i_gnt = bus.I_REQ;
            end
            // Hand the next tie to the port that did not just win
            if (d_gnt) begin
                prio_d_d = 1'b0;
            end else if (i_gnt) begin
                prio_d_d = 1'b1;
            end
`else
            d_gnt = bus.D_REQ;
            i_gnt = bus.I_REQ & ~bus.D_REQ;
`endif
        end
    end

    // Next-state logic: latch the winner into the SRAM registers, capture data, hand back
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        sram_csn_d  = sram_csn_q;
        sram_wen_d  = sram_wen_q;
        sram_addr_d = sram_addr_q;
        sram_be_d   = sram_be_q;
        sram_di_d   = sram_di_q;
        i_rvalid_d  = i_rvalid_q;
        d_rvalid_d  = d_rvalid_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        resp        = 32'h0;
        own_rready  = owner_q ? bus.D_RREADY : bus.I_RREADY;

        unique case (state_q)
            StIdle: begin
                if (i_gnt || d_gnt) begin
                    state_d     = StAccess;
                    owner_d     = d_gnt;
                    sram_csn_d  = 1'b0;
                    sram_wen_d  = !(d_gnt && bus.D_WE);
                    sram_addr_d = d_gnt ? bus.D_ADDR : bus.I_ADDR;
                    sram_be_d   = (d_gnt && bus.D_WE) ? bus.D_BE : 4'b0000;
                    sram_di_d   = d_gnt ? bus.D_WDATA : sram_di_q;
                end
            end
            StAccess: begin
                state_d    = StResp;
                sram_csn_d = 1'b1;
                sram_wen_d = 1'b1;
                // Writes acknowledge with zero so SRAM_DOUT is only looked at for reads
                resp       = sram_wen_q ? bus.SRAM_DOUT : 32'h0;
                if (owner_q) begin
                    d_rdata_d  = resp;
                    d_rvalid_d = 1'b1;
                end else begin
                    i_rdata_d  = resp;
                    i_rvalid_d = 1'b1;
                end
            end
            StResp: begin
                if (own_rready) begin
                    state_d    = StIdle;
                    i_rvalid_d = 1'b0;
                    d_rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            sram_csn_q  <= 1'b1;
            sram_wen_q  <= 1'b1;
            sram_addr_q <= '0;
            sram_be_q   <= 4'b0000;
            sram_di_q   <= 32'h0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
`ifdef SRAM_ARB_RR_EN
            prio_d_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            sram_csn_q  <= sram_csn_d;
            sram_wen_q  <= sram_wen_d;
            sram_addr_q <= sram_addr_d;
            sram_be_q   <= sram_be_d;
            sram_di_q   <= sram_di_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef SRAM_ARB_RR_EN
            prio_d_q    <= prio_d_d;
`endif
        end
    end

    assign bus.I_GNT     = i_gnt;
    assign bus.D_GNT     = d_gnt;
    assign bus.I_RVALID  = i_rvalid_q;
    assign bus.D_RVALID  = d_rvalid_q;
    assign bus.I_RDATA   = i_rdata_q;
    assign bus.D_RDATA   = d_rdata_q;
    assign bus.SRAM_CSN  = sram_csn_q;
    assign bus.SRAM_WEN  = sram_wen_q;
    assign bus.SRAM_ADDR = sram_addr_q;
    assign bus.SRAM_BE   = sram_be_q;
    assign bus.SRAM_DI   = sram_di_q;

endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: drives both request ports of sram_port_arb against a behavioural SRAM
// and checks responses and SRAM-side timing against a word-level memory model.
module tb_sram_port_arb;
    localparam int unsigned AW = 12;
`ifdef SRAM_ARB_RR_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    sram_port_arb_if #(.AWIDTH(AW)) bus ();
    sram_port_arb #(.AWIDTH(AW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    // Behavioural single-port SRAM: combinational read while selected, byte-lane write at edge
    logic [31:0] sram_mem [0:(1<<AW)-1];
    assign bus.SRAM_DOUT = bus.SRAM_CSN ? 32'hxxxx_xxxx : sram_mem[bus.SRAM_ADDR];
    always @(posedge CLK) begin
        if (!bus.SRAM_CSN && !bus.SRAM_WEN) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.SRAM_BE[b]) sram_mem[bus.SRAM_ADDR][8*b +: 8] <= bus.SRAM_DI[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] model_mem [0:(1<<AW)-1];
    bit          last_d;            // port granted most recently (1 = data)
    logic [31:0] exp_i_hold;        // value I_RDATA must keep while idle
    logic [31:0] exp_d_hold;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One complete transaction on one port; the other port requests while the response is held
    task automatic xfer(input bit is_d, input bit we, input logic [AW-1:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input int hold);
        logic [31:0] exp;
        int n;
        bit wr;
        wr = is_d && we;
        if (is_d) begin
            bus.D_REQ = 1'b1; bus.D_WE = we; bus.D_ADDR = addr; bus.D_BE = be; bus.D_WDATA = wdata;
        end else begin
            bus.I_REQ = 1'b1; bus.I_ADDR = addr;
        end
        #1;
        n = 0;
        while (!(is_d ? bus.D_GNT : bus.I_GNT) && n < 16) begin
            step();
            n++;
        end
        chk("gnt_wait", 32'(n), 32'd0);
        chk("gnt_other", 32'(is_d ? bus.I_GNT : bus.D_GNT), 32'd0);
        last_d = is_d;
        exp = wr ? 32'h0 : model_mem[addr];
        if (wr) model_mem[addr] = apply_be(model_mem[addr], wdata, be);
        step();
        bus.D_REQ = 1'b0;
        bus.I_REQ = 1'b0;
        #1;
        // ACCESS cycle
        chk("acc_csn", 32'(bus.SRAM_CSN), 32'd0);
        chk("acc_wen", 32'(bus.SRAM_WEN), 32'(!wr));
        chk("acc_addr", 32'(bus.SRAM_ADDR), 32'(addr));
        chk("acc_be", 32'(bus.SRAM_BE), 32'(wr ? be : 4'b0000));
        if (wr) chk("acc_di", bus.SRAM_DI, wdata);
        chk("acc_gnt", 32'({bus.I_GNT, bus.D_GNT}), 32'd0);
        chk("acc_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), 32'd0);
        step();
        // RESP: response must be up exactly two cycles after the grant, and hold while stalled
        for (int k = 0; k < hold; k++) begin
            if (is_d) begin
                bus.I_REQ = 1'b1; bus.I_ADDR = addr;
            end else begin
                bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = addr;
            end
            #1;
            chk("stall_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), is_d ? 32'd1 : 32'd2);
            chk("stall_rdata", is_d ? bus.D_RDATA : bus.I_RDATA, exp);
            chk("stall_csn", 32'(bus.SRAM_CSN), 32'd1);
            chk("stall_gnt", 32'({bus.I_GNT, bus.D_GNT}), 32'd0);
            step();
        end
        bus.I_REQ = 1'b0;
        bus.D_REQ = 1'b0;
        if (is_d) bus.D_RREADY = 1'b1; else bus.I_RREADY = 1'b1;
        #1;
        chk("resp_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), is_d ? 32'd1 : 32'd2);
        chk("resp_rdata", is_d ? bus.D_RDATA : bus.I_RDATA, exp);
        chk("resp_csn", 32'(bus.SRAM_CSN), 32'd1);
        step();
        bus.I_RREADY = 1'b0;
        bus.D_RREADY = 1'b0;
        if (is_d) exp_d_hold = exp; else exp_i_hold = exp;
        #1;
        chk("idle_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), 32'd0);
        chk("idle_i_rdata", bus.I_RDATA, exp_i_hold);
        chk("idle_d_rdata", bus.D_RDATA, exp_d_hold);
        chk("idle_csn_wen", 32'({bus.SRAM_CSN, bus.SRAM_WEN}), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int cyc;
        int prev;
        bit saw_i;
        bit saw_d;

        // Reset with both ports requesting: no grant may leak out while reset is high
        RST = 1'b1;
        bus.I_REQ = 1'b1; bus.I_ADDR = '0; bus.I_RREADY = 1'b0;
        bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = '0; bus.D_BE = 4'b0000;
        bus.D_WDATA = 32'h0; bus.D_RREADY = 1'b0;
        step();
        step();
        chk("rst_gnt", 32'({bus.I_GNT, bus.D_GNT}), 32'd0);
        chk("rst_csn_wen", 32'({bus.SRAM_CSN, bus.SRAM_WEN}), 32'd3);
        chk("rst_addr", 32'(bus.SRAM_ADDR), 32'd0);
        chk("rst_be", 32'(bus.SRAM_BE), 32'd0);
        chk("rst_di", bus.SRAM_DI, 32'h0);
        chk("rst_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), 32'd0);
        chk("rst_i_rdata", bus.I_RDATA, 32'h0);
        chk("rst_d_rdata", bus.D_RDATA, 32'h0);
        bus.I_REQ = 1'b0;
        bus.D_REQ = 1'b0;
        RST = 1'b0;
        last_d = 1'b0;
        exp_i_hold = 32'h0;
        exp_d_hold = 32'h0;
        step();

        // Data write then instruction read of the same word
        xfer(1'b1, 1'b1, 12'h010, 4'b1111, 32'hDEADBEEF, 0);
        xfer(1'b0, 1'b0, 12'h010, 4'b0000, 32'h0, 0);
        chk("i_read_deadbeef", bus.I_RDATA, 32'hDEADBEEF);

        // Partial byte-enable write merges with existing word; empty BE leaves it alone
        xfer(1'b1, 1'b1, 12'h020, 4'b1111, 32'hAABBCCDD, 0);
        xfer(1'b1, 1'b1, 12'h020, 4'b0101, 32'h11223344, 0);
        xfer(1'b1, 1'b0, 12'h020, 4'b0000, 32'h0, 0);
        chk("d_read_merged", bus.D_RDATA, 32'hAA22CC44);
        xfer(1'b1, 1'b1, 12'h020, 4'b0000, 32'hFFFFFFFF, 0);
        xfer(1'b1, 1'b0, 12'h020, 4'b0000, 32'h0, 0);
        chk("d_read_be0", bus.D_RDATA, 32'hAA22CC44);

        // Data read stalled by RREADY low for 5 cycles while the I port keeps requesting
        xfer(1'b1, 1'b0, 12'h010, 4'b0000, 32'h0, 5);

        // Reset during ACCESS of a read discards it; the next read completes normally
        bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = 12'h010;
        #1;
        chk("rstacc_gnt", 32'(bus.D_GNT), 32'd1);
        step();
        bus.D_REQ = 1'b0;
        chk("rstacc_csn", 32'(bus.SRAM_CSN), 32'd0);
        RST = 1'b1;
        bus.I_REQ = 1'b1;
        step();
        chk("rstacc_gnt_in_rst", 32'({bus.I_GNT, bus.D_GNT}), 32'd0);
        chk("rstacc_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), 32'd0);
        chk("rstacc_csn_after", 32'(bus.SRAM_CSN), 32'd1);
        chk("rstacc_d_rdata", bus.D_RDATA, 32'h0);
        RST = 1'b0;
        bus.I_REQ = 1'b0;
        last_d = 1'b0;
        exp_i_hold = 32'h0;
        exp_d_hold = 32'h0;
        step();
        xfer(1'b0, 1'b0, 12'h010, 4'b0000, 32'h0, 0);
        chk("rstacc_next_read", bus.I_RDATA, 32'hDEADBEEF);

        // Both ports requesting continuously for 6 grants, responses accepted at once
        RST = 1'b1;
        step();
        RST = 1'b0;
        last_d = 1'b0;
        exp_i_hold = 32'h0;
        exp_d_hold = 32'h0;
        bus.I_ADDR = 12'h010; bus.D_ADDR = 12'h010; bus.D_WE = 1'b0;
        bus.I_RREADY = 1'b1; bus.D_RREADY = 1'b1;
        bus.I_REQ = 1'b1; bus.D_REQ = 1'b1;
        #1;
        grants = 0; cyc = 0; prev = 0; saw_i = 1'b0; saw_d = 1'b0;
        while (grants < 6 && cyc < 40) begin
            if (bus.I_GNT || bus.D_GNT) begin
                chk("arb_onehot", 32'(bus.I_GNT & bus.D_GNT), 32'd0);
                chk("arb_order", 32'(bus.D_GNT), 32'(RoundRobin ? !last_d : 1'b1));
                if (grants > 0) chk("arb_spacing", 32'(cyc - prev), 32'd3);
                last_d = bus.D_GNT;
                if (bus.D_GNT) saw_d = 1'b1; else saw_i = 1'b1;
                prev = cyc;
                grants++;
            end
            step();
            cyc++;
        end
        chk("arb_grants", 32'(grants), 32'd6);
        bus.I_REQ = 1'b0;
        bus.D_REQ = 1'b0;
        step();
        step();
        bus.I_RREADY = 1'b0;
        bus.D_RREADY = 1'b0;
        if (saw_i) exp_i_hold = model_mem[12'h010];
        if (saw_d) exp_d_hold = model_mem[12'h010];
        #1;
        chk("arb_end_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), 32'd0);
        chk("arb_end_i_rdata", bus.I_RDATA, exp_i_hold);
        chk("arb_end_d_rdata", bus.D_RDATA, exp_d_hold);

        // Random traffic over a small window so reads hit earlier writes
        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, 1'b1, 12'(12'h100 + i), 4'b1111, $urandom, 0);
        end
        for (int i = 0; i < 48; i++) begin
            bit          r_is_d;
            bit          r_we;
            logic [AW-1:0] r_addr;
            r_is_d = 1'($urandom_range(0, 1));
            r_we   = r_is_d && 1'($urandom_range(0, 1));
            r_addr = 12'(12'h100 + $urandom_range(0, 15));
            xfer(r_is_d, r_we, r_addr, 4'($urandom), $urandom, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
